// File: rtl/multi_player_renderer_pkg.sv
// Shared definitions for the multi-player sprite renderer.
//   state_t        : renderer FSM states
//   ERASE_COLOUR   : colour written when a sprite or the screen is wiped
//   player_colour  : colour of player idx (idx + 1, so player 0 never draws black)
package multi_player_renderer_pkg;

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_INIT,
    ST_IDLE,
    ST_ERASE,
    ST_UPDATE,
    ST_DRAW
  } state_t;

  localparam logic [2:0] ERASE_COLOUR = 3'b000;

  function automatic logic [2:0] player_colour(input logic [2:0] idx);
    return idx + 3'd1;
  endfunction

endpackage

// File: rtl/multi_player_renderer_frame_tick.sv
// Frame-rate divider for the renderer.
//   clk    : system clock
//   resetn : asynchronous active-low reset, clears the divider
//   tick   : one-cycle pulse every FRAME_DIV clk cycles
module frame_tick #(
  parameter int FRAME_DIV = 833334
) (
  input  logic clk,
  input  logic resetn,
  output logic tick
);

  localparam int CW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(FRAME_DIV - 1);

  logic [CW-1:0] cnt;

  // Free-running modulo-FRAME_DIV counter; tick marks its final count.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/multi_player_renderer.sv
// Multi-player sprite renderer: clears the screen, places each player's
// sprite on its own row band, then on every frame tick erases, moves and
// redraws each player in turn, emitting one pixel write per cycle.
//   clk, resetn         : clock and asynchronous active-low reset
//   restart_n           : synchronous active-low game restart
//   dir, hold           : per-player direction (1 = right) and freeze
//   x, y, colour, plot  : registered pixel-write port (zeroed when plot = 0)
//   score               : packed per-player move counters (saturating)
//   busy, overrun       : FSM not idle; sticky "tick arrived while busy"
module multi_player_renderer
  import multi_player_renderer_pkg::*;
#(
  parameter int N_PLAYERS = 2,
  parameter int SPR_W     = 2,
  parameter int SPR_H     = 2,
  parameter int SCR_W     = 160,
  parameter int SCR_H     = 120,
  parameter int FRAME_DIV = 833334,
  parameter int SCORE_W   = 10
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         restart_n,
  input  logic [N_PLAYERS-1:0]         dir,
  input  logic [N_PLAYERS-1:0]         hold,
  output logic [7:0]                   x,
  output logic [7:0]                   y,
  output logic [2:0]                   colour,
  output logic                         plot,
  output logic [N_PLAYERS*SCORE_W-1:0] score,
  output logic                         busy,
  output logic                         overrun
);

  localparam int PW = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1;
  localparam logic [PW-1:0]      LAST_P     = PW'(N_PLAYERS - 1);
  localparam logic [7:0]         SCR_W_LAST = 8'(SCR_W - 1);
  localparam logic [7:0]         SCR_H_LAST = 8'(SCR_H - 1);
  localparam logic [7:0]         SPR_W_LAST = 8'(SPR_W - 1);
  localparam logic [7:0]         SPR_H_LAST = 8'(SPR_H - 1);
  localparam logic [7:0]         X_MAX      = 8'(SCR_W - SPR_W);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;

  state_t             state, state_next;
  logic [PW-1:0]      p, p_next;
  logic [7:0]         col, row, col_next, row_next;
  logic [7:0]         pos_x   [N_PLAYERS];
  logic [SCORE_W-1:0] score_q [N_PLAYERS];
  logic               tick;
  logic               wr_en;
  logic [7:0]         wr_x, wr_y;
  logic [2:0]         wr_colour;
  logic               spr_last;
  logic [7:0]         spr_col_next, spr_row_next;
  logic [7:0]         cur_x, cur_y;
  logic               moved;
  logic [7:0]         new_x;

  frame_tick #(.FRAME_DIV(FRAME_DIV)) u_frame_tick (
    .clk    (clk),
    .resetn (resetn),
    .tick   (tick)
  );

  // Players only move horizontally, so each one's row band is fixed by index.
  function automatic logic [7:0] home_row(input logic [PW-1:0] idx);
    return 8'(SCR_H - (int'(idx) + 1) * (SPR_H + 2));
  endfunction

  assign cur_x = pos_x[p];
  assign cur_y = home_row(p);
  assign busy  = (state != ST_IDLE);

  for (genvar i = 0; i < N_PLAYERS; i++) begin : g_score
    assign score[i*SCORE_W +: SCORE_W] = score_q[i];
  end

  // Row-major walk over the sprite box; spr_last flags its final pixel.
  always_comb begin
    spr_last     = (col == SPR_W_LAST) && (row == SPR_H_LAST);
    spr_col_next = col + 8'd1;
    spr_row_next = row;
    if (col == SPR_W_LAST) begin
      spr_col_next = '0;
      spr_row_next = spr_last ? 8'd0 : row + 8'd1;
    end
  end

  // Movement rule for the current player; only committed in UPDATE.
  always_comb begin
    moved = 1'b0;
    new_x = cur_x;
    if (!hold[p]) begin
      if (dir[p] && (cur_x < X_MAX)) begin
        new_x = cur_x + 8'd1;
        moved = 1'b1;
      end else if (!dir[p] && (cur_x != 8'd0)) begin
        new_x = cur_x - 8'd1;
        moved = 1'b1;
      end
    end
  end

  // State, player index and pixel counters.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ST_CLEAR;
      p     <= '0;
      col   <= '0;
      row   <= '0;
    end else begin
      state <= state_next;
      p     <= p_next;
      col   <= col_next;
      row   <= row_next;
    end
  end

  // Next state plus the pixel write this cycle produces; restart overrides all.
  always_comb begin
    state_next = state;
    p_next     = p;
    col_next   = col;
    row_next   = row;
    wr_en      = 1'b0;
    wr_x       = '0;
    wr_y       = '0;
    wr_colour  = ERASE_COLOUR;
    case (state)
      ST_CLEAR: begin
        wr_en = 1'b1;
        wr_x  = col;
        wr_y  = row;
        if (col == SCR_W_LAST) begin
          col_next = '0;
          if (row == SCR_H_LAST) begin
            row_next   = '0;
            p_next     = '0;
            state_next = ST_INIT;
          end else begin
            row_next = row + 8'd1;
          end
        end else begin
          col_next = col + 8'd1;
        end
      end
      ST_INIT: begin
        wr_en     = 1'b1;
        wr_x      = col;
        wr_y      = cur_y + row;
        wr_colour = player_colour(3'(p));
        col_next  = spr_col_next;
        row_next  = spr_row_next;
        if (spr_last) begin
          if (p == LAST_P) begin
            p_next     = '0;
            state_next = ST_IDLE;
          end else begin
            p_next = p + 1'b1;
          end
        end
      end
      ST_IDLE: begin
        if (tick) begin
          p_next     = '0;
          state_next = ST_ERASE;
        end
      end
      ST_ERASE: begin
        wr_en    = 1'b1;
        wr_x     = cur_x + col;
        wr_y     = cur_y + row;
        col_next = spr_col_next;
        row_next = spr_row_next;
        if (spr_last) state_next = ST_UPDATE;
      end
      ST_UPDATE: begin
        state_next = ST_DRAW;
      end
      ST_DRAW: begin
        wr_en     = 1'b1;
        wr_x      = cur_x + col;
        wr_y      = cur_y + row;
        wr_colour = player_colour(3'(p));
        col_next  = spr_col_next;
        row_next  = spr_row_next;
        if (spr_last) begin
          if (p == LAST_P) begin
            p_next     = '0;
            state_next = ST_IDLE;
          end else begin
            p_next     = p + 1'b1;
            state_next = ST_ERASE;
          end
        end
      end
      default: begin
        state_next = ST_CLEAR;
      end
    endcase
    if (!restart_n) begin
      state_next = ST_CLEAR;
      p_next     = '0;
      col_next   = '0;
      row_next   = '0;
      wr_en      = 1'b0;
    end
  end

  // Registered pixel port, player positions, scores and the overrun flag.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      plot    <= 1'b0;
      x       <= '0;
      y       <= '0;
      colour  <= ERASE_COLOUR;
      overrun <= 1'b0;
      for (int i = 0; i < N_PLAYERS; i++) begin
        pos_x[i]   <= '0;
        score_q[i] <= '0;
      end
    end else begin
      plot   <= wr_en;
      x      <= wr_en ? wr_x : 8'd0;
      y      <= wr_en ? wr_y : 8'd0;
      colour <= wr_en ? wr_colour : ERASE_COLOUR;
      if (!restart_n) begin
        overrun <= 1'b0;
        for (int i = 0; i < N_PLAYERS; i++) begin
          score_q[i] <= '0;
        end
      end else begin
        if (tick && (state != ST_IDLE)) overrun <= 1'b1;
        if (state == ST_INIT) pos_x[p] <= '0;
        if ((state == ST_UPDATE) && moved) begin
          pos_x[p] <= new_x;
          if (score_q[p] != SCORE_MAX) score_q[p] <= score_q[p] + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_multi_player_renderer.sv
// Testbench for multi_player_renderer on a 16x12 screen with two 2x2 players.
// Instance A carries the pixel scoreboard, instance B uses 3-bit scores and
// instance C a very short frame period.
module tb_multi_player_renderer;

  localparam int SW   = 16;
  localparam int SH   = 12;
  localparam int PSW  = 2;
  localparam int PSH  = 2;
  localparam int NP   = 2;
  localparam int FD   = 200;
  localparam int SCW  = 10;
  localparam int SCWB = 3;
  localparam int FRAME_BUSY = NP * (2 * PSW * PSH + 1);

  logic clk;
  logic resetn;

  logic          restartA, restartB, restartC;
  logic [NP-1:0] dir, hold, dirB, holdB, dirC, holdC;

  logic [7:0] x, y, xB, yB, xC, yC;
  logic [2:0] colour, colourB, colourC;
  logic       plot, plotB, plotC;
  logic       busy, busyB, busyC;
  logic       overrun, overrunB, overrunC;
  logic [NP*SCW-1:0]  score, scoreC;
  logic [NP*SCWB-1:0] scoreB;

  int checks = 0;
  int errors = 0;

  logic [18:0] expQ[$];
  int modelX[NP];
  int modelScore[NP];

  multi_player_renderer #(
    .N_PLAYERS(NP), .SPR_W(PSW), .SPR_H(PSH), .SCR_W(SW), .SCR_H(SH),
    .FRAME_DIV(FD), .SCORE_W(SCW)
  ) dutA (
    .clk(clk), .resetn(resetn), .restart_n(restartA), .dir(dir), .hold(hold),
    .x(x), .y(y), .colour(colour), .plot(plot), .score(score),
    .busy(busy), .overrun(overrun)
  );

  multi_player_renderer #(
    .N_PLAYERS(NP), .SPR_W(PSW), .SPR_H(PSH), .SCR_W(SW), .SCR_H(SH),
    .FRAME_DIV(FD), .SCORE_W(SCWB)
  ) dutB (
    .clk(clk), .resetn(resetn), .restart_n(restartB), .dir(dirB), .hold(holdB),
    .x(xB), .y(yB), .colour(colourB), .plot(plotB), .score(scoreB),
    .busy(busyB), .overrun(overrunB)
  );

  multi_player_renderer #(
    .N_PLAYERS(NP), .SPR_W(PSW), .SPR_H(PSH), .SCR_W(SW), .SCR_H(SH),
    .FRAME_DIV(5), .SCORE_W(SCW)
  ) dutC (
    .clk(clk), .resetn(resetn), .restart_n(restartC), .dir(dirC), .hold(holdC),
    .x(xC), .y(yC), .colour(colourC), .plot(plotC), .score(scoreC),
    .busy(busyC), .overrun(overrunC)
  );

  // 10 ns clock; all sampling happens on the falling edge.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic int homeRow(input int p);
    return SH - (p + 1) * (PSH + 2);
  endfunction

  task automatic pushPixel(input int px, input int py, input int c);
    expQ.push_back({8'(px), 8'(py), 3'(c)});
  endtask

  task automatic pushSprite(input int px, input int py, input int c);
    for (int r = 0; r < PSH; r++)
      for (int cc = 0; cc < PSW; cc++)
        pushPixel(px + cc, py + r, c);
  endtask

  // Whole-screen clear followed by every player placed at x = 0.
  task automatic pushClearInit();
    for (int r = 0; r < SH; r++)
      for (int c = 0; c < SW; c++)
        pushPixel(c, r, 0);
    for (int p = 0; p < NP; p++) begin
      modelX[p] = 0;
      pushSprite(0, homeRow(p), p + 1);
    end
  endtask

  // One frame: erase, move by the game rules, redraw, for each player.
  task automatic pushFrame(input logic [NP-1:0] d, input logic [NP-1:0] h);
    for (int p = 0; p < NP; p++) begin
      pushSprite(modelX[p], homeRow(p), 0);
      if (!h[p]) begin
        if (d[p] && modelX[p] < SW - PSW) begin
          modelX[p]++;
          if (modelScore[p] < (1 << SCW) - 1) modelScore[p]++;
        end else if (!d[p] && modelX[p] > 0) begin
          modelX[p]--;
          if (modelScore[p] < (1 << SCW) - 1) modelScore[p]++;
        end
      end
      pushSprite(modelX[p], homeRow(p), p + 1);
    end
  endtask

  // Drive one frame's inputs on A, wait for it to finish and check results.
  task automatic applyStimulus(input logic [NP-1:0] d, input logic [NP-1:0] h);
    int n;
    int cnt;
    dir  = d;
    hold = h;
    pushFrame(d, h);
    n = 0;
    while (!busy && n < 600) begin
      @(negedge clk);
      n++;
    end
    checkOutput("frameStart", busy, 1);
    if (!busy) return;
    cnt = 0;
    while (busy && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    checkOutput("busyCycles", cnt, FRAME_BUSY);
    @(negedge clk);
    checkOutput("frameQueueEmpty", expQ.size(), 0);
    for (int p = 0; p < NP; p++)
      checkOutput("frameScore", score[p*SCW +: SCW], modelScore[p]);
  endtask

  // Pixel scoreboard for instance A.
  always @(negedge clk) begin
    logic [18:0] expPix;
    if (resetn) begin
      if (plot) begin
        checkOutput("plotExpected", expQ.size() != 0, 1);
        if (expQ.size() != 0) begin
          expPix = expQ.pop_front();
          checkOutput("pixel", {x, y, colour}, expPix);
        end
      end else begin
        checkOutput("noPlotZero", {x, y, colour}, 0);
      end
    end
  end

  initial begin
    int n;
    clk      = 1'b0;
    resetn   = 1'b0;
    restartA = 1'b1;
    restartB = 1'b1;
    restartC = 1'b1;
    dir = '0; hold = '0; dirB = '0; holdB = '0; dirC = '0; holdC = '0;
    for (int p = 0; p < NP; p++) begin
      modelX[p] = 0;
      modelScore[p] = 0;
    end
    repeat (2) @(negedge clk);
    checkOutput("rstPlot", plot, 0);
    checkOutput("rstXYC", {x, y, colour}, 0);
    checkOutput("rstBusy", busy, 1);
    checkOutput("rstScore", score, 0);
    checkOutput("rstOverrun", overrun, 0);

    pushClearInit();
    resetn = 1'b1;
    @(negedge clk);
    checkOutput("firstPlot", {plot, x, y, colour}, {1'b1, 19'h0});

    fork
      begin : procA
        n = 0;
        while (busy && n < 400) begin
          @(negedge clk);
          n++;
        end
        checkOutput("initDone", busy, 0);
        @(negedge clk);
        checkOutput("initQueueEmpty", expQ.size(), 0);
        repeat (2) applyStimulus(2'b00, 2'b00);
        repeat (3) applyStimulus(2'b01, 2'b10);
        repeat (20) applyStimulus(2'b11, 2'b00);
        for (int p = 0; p < NP; p++) begin
          checkOutput("edgeX", modelX[p], SW - PSW);
          checkOutput("edgeScore", score[p*SCW +: SCW], 14);
        end

        // Restart while player 1 is being drawn.
        dir  = 2'b11;
        hold = 2'b00;
        pushFrame(2'b11, 2'b00);
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!(plot && colour == 3'd2) && n < 600);
        checkOutput("draw1Seen", plot && colour == 3'd2, 1);
        restartA = 1'b0;
        #1;
        expQ.delete();
        for (int p = 0; p < NP; p++) modelScore[p] = 0;
        pushClearInit();
        @(negedge clk);
        checkOutput("restartScore", score, 0);
        checkOutput("restartOverrun", overrun, 0);
        checkOutput("restartPlotGap", plot, 0);
        restartA = 1'b1;
        @(negedge clk);
        checkOutput("restartFirstPlot", {plot, x, y}, {1'b1, 16'h0});
        n = 0;
        while (busy && n < 400) begin
          @(negedge clk);
          n++;
        end
        checkOutput("restartDone", busy, 0);
        @(negedge clk);
        checkOutput("restartQueueEmpty", expQ.size(), 0);
        applyStimulus(2'b11, 2'b00);
      end
      begin : procB
        int nb;
        int cnt;
        nb = 0;
        while (busyB && nb < 400) begin
          @(negedge clk);
          nb++;
        end
        checkOutput("bInitDone", busyB, 0);
        for (int k = 1; k <= 12; k++) begin
          dirB  = (k % 2 == 1) ? 2'b11 : 2'b00;
          holdB = 2'b00;
          nb = 0;
          while (!busyB && nb < 600) begin
            @(negedge clk);
            nb++;
          end
          checkOutput("bFrameStart", busyB, 1);
          cnt = 0;
          while (busyB && cnt < 100) begin
            @(negedge clk);
            cnt++;
          end
          @(negedge clk);
          for (int p = 0; p < NP; p++)
            checkOutput("bSatScore", scoreB[p*SCWB +: SCWB], (k < 7) ? k : 7);
        end
        checkOutput("bIdleOutputs", {plotB, xB, yB, colourB}, 0);
      end
      begin : procC
        int nc;
        int lowCnt;
        nc = 0;
        while (!overrunC && nc < 300) begin
          @(negedge clk);
          nc++;
        end
        checkOutput("overrunSet", overrunC, 1);
        checkOutput("overrunInFirstFrame", nc < 250, 1);
        lowCnt = 0;
        repeat (100) begin
          @(negedge clk);
          if (!overrunC) lowCnt++;
        end
        checkOutput("overrunSticky", lowCnt, 0);
        restartC = 1'b0;
        @(negedge clk);
        checkOutput("overrunRestartClear", overrunC, 0);
        checkOutput("cRestartScore", scoreC, 0);
        restartC = 1'b1;
        nc = 0;
        while (!overrunC && nc < 300) begin
          @(negedge clk);
          nc++;
        end
        checkOutput("overrunSetAgain", overrunC, 1);
      end
    join

    @(negedge clk);
    resetn = 1'b0;
    #1;
    checkOutput("rst2PlotXYC", {plot, x, y, colour}, 0);
    checkOutput("rst2Busy", busy, 1);
    checkOutput("rst2Overrun", overrun, 0);
    checkOutput("rst2ScoreB", scoreB, 0);
    checkOutput("rst2OverrunB", overrunB, 0);
    checkOutput("rst2OverrunC", overrunC, 0);
    checkOutput("rst2OutC", {plotC, xC, yC, colourC, busyC}, 1);
    $display("[TB] all stimulus applied");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_player_renderer.md
MULTI_PLAYER_RENDERER -- requirements
Module: multi_player_renderer

Interface
REQ-001 Parameter N_PLAYERS, default 2, number of player sprites (1..7).
REQ-002 Parameter SPR_W, default 2, sprite width in pixels.
REQ-003 Parameter SPR_H, default 2, sprite height in pixels.
REQ-004 Parameter SCR_W, default 160, and SCR_H, default 120, screen size in pixels.
REQ-005 Parameter FRAME_DIV, default 833334, clk cycles per frame tick.
REQ-006 Parameter SCORE_W, default 10, width of each score counter.
REQ-007 clk  input  1  system clock; single clock domain.
REQ-008 resetn  input  1  asynchronous active-low reset.
REQ-009 restart_n  input  1  synchronous active-low game restart.
REQ-010 dir  input  N_PLAYERS  per-player direction: 1 = right, 0 = left.
REQ-011 hold  input  N_PLAYERS  per-player freeze: 1 = no movement this frame.
REQ-012 x  output  8  pixel column of the current write.
REQ-013 y  output  8  pixel row of the current write.
REQ-014 colour  output  3  pixel colour of the current write.
REQ-015 plot  output  1  high only in cycles that carry a valid pixel write.
REQ-016 score  output  N_PLAYERS*SCORE_W  packed scores; player i occupies [i*SCORE_W +: SCORE_W].
REQ-017 busy  output  1  high whenever the FSM is not in IDLE.
REQ-018 overrun  output  1  sticky; set when a frame tick arrives while busy.

Function
REQ-019 FSM states: CLEAR, INIT, IDLE, ERASE, UPDATE, DRAW; a player index p (0..N_PLAYERS-1) qualifies INIT/ERASE/UPDATE/DRAW.
REQ-020 CLEAR emits SCR_W*SCR_H writes, one per cycle, row-major from (0,0), colour 000; the next state is INIT with p=0.
REQ-021 INIT sets player p to x=0, y=SCR_H-(p+1)*(SPR_H+2), then draws it; after the last player the FSM goes to IDLE.
REQ-022 Player p colour = p+1 (3 bits); erase colour = 000.
REQ-023 Sprite draw/erase emits SPR_W*SPR_H writes, row-major, one per cycle, at (pos_x+col, pos_y+row).
REQ-024 On a frame tick, IDLE goes to ERASE(0); the sequence per player is ERASE(p) -> UPDATE(p) -> DRAW(p) -> ERASE(p+1); after DRAW(N_PLAYERS-1) the FSM returns to IDLE.
REQ-025 UPDATE lasts exactly 1 cycle with plot=0.
REQ-026 UPDATE rule, in order:
  - if hold[p]=1: no move;
  - else if dir[p]=1 and pos_x < SCR_W-SPR_W: pos_x+1;
  - else if dir[p]=0 and pos_x > 0: pos_x-1.
REQ-027 Score p increments by 1 only when pos_x actually changed, and saturates at 2^SCORE_W-1.
REQ-028 dir and hold are sampled in the UPDATE cycle only.
REQ-029 A frame tick while busy is dropped and sets overrun; no tick is queued.
REQ-030 Frame latency: tick to IDLE = N_PLAYERS*(2*SPR_W*SPR_H+1)+1 cycles.
REQ-031 When plot=0, x, y and colour are 0.
REQ-032 restart_n=0 in any state forces CLEAR on the next cycle, resets the pixel counter, zeroes scores and clears overrun; the frame divider is unaffected.

Reset
REQ-033 resetn=0 asynchronously forces: state CLEAR, p=0, pixel counter 0, positions 0, scores 0, plot 0, x/y/colour 0, overrun 0, busy 1, frame divider 0.
REQ-034 After resetn deasserts, the first CLEAR write (0,0) appears on the first clk edge.

Structure
REQ-035 A shared package holds the state enumeration, the erase colour constant and the player-colour function.
REQ-036 The frame divider is a sub-module frame_tick (parameter FRAME_DIV; ports clk, resetn, tick) that pulses tick for 1 cycle every FRAME_DIV cycles.
REQ-037 x, y, colour and plot are registered outputs.

Verification (SCR_W=16, SCR_H=12, SPR_W=SPR_H=2, N_PLAYERS=2, FRAME_DIV=200)
REQ-038 Reset release -> 192 plot cycles of colour 000 covering (0,0)..(15,11), then 4 writes colour 001 at rows 8-9, then 4 writes colour 010 at rows 4-5, then busy=0.
REQ-039 dir=2'b11, hold=0, 20 frames -> both players reach x=14 after 14 frames; scores stop at 14; the last 6 frames only redraw at x=14.
REQ-040 dir=2'b00 from x=0 -> no movement, score unchanged; hold[1]=1 with dir[0]=1 -> only player 0 moves and scores.
REQ-041 SCORE_W=3, dir toggled each frame for 12 frames -> score saturates at 7.
REQ-042 restart_n pulsed mid-DRAW(1) -> next cycle starts CLEAR at (0,0); scores read 0; the full CLEAR+INIT sequence repeats.
REQ-043 FRAME_DIV=5 -> overrun=1 within the first frame; it stays set until restart_n or resetn.
